// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: packs a byte stream big-endian into 32-bit words,
// writes them from address 0, then releases the core. Optional checksum byte: IM_LOADER_CHECKSUM_EN.
module im_loader (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        start,
  input  logic [15:0] word_cnt,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst_f,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] wc_q;
  logic [1:0]  byte_cnt;
  logic        accept;
  logic        start_ok;
  logic        last_word;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    in_ready  = (state == LOAD) || (state == CHECK);
    im_we     = (state == WRITE);
    busy      = (state == LOAD) || (state == WRITE) || (state == CHECK);
    done      = (state == DONE) && !err;
    cpu_rst_f = (state == DONE) && !err;
    accept    = in_ready && in_valid;
    start_ok  = start && ((state == IDLE) || (state == DONE));
    // Widened so a full 0xFFFF-word load cannot wrap the comparison.
    last_word = ({1'b0, im_addr} + 17'd1) >= {1'b0, wc_q};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) state_nxt = (word_cnt == 16'd0) ? DONE : LOAD;
      end
      LOAD: begin
        if (accept && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        if (!last_word) begin
          state_nxt = LOAD;
        end else begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
      CHECK: begin
        if (accept) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state    <= IDLE;
      im_addr  <= 16'd0;
      im_wdata <= 32'd0;
      byte_cnt <= 2'd0;
      wc_q     <= 16'd0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum     <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        wc_q     <= word_cnt;
        im_addr  <= 16'd0;
        byte_cnt <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
        err_q    <= 1'b0;
`endif
      end else begin
        if ((state == LOAD) && accept) begin
          im_wdata <= {im_wdata[23:0], in_data};
          byte_cnt <= byte_cnt + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          csum     <= csum ^ in_data;
`endif
        end
        if (state == WRITE) im_addr <= im_addr + 16'd1;
`ifdef IM_LOADER_CHECKSUM_EN
        if ((state == CHECK) && accept) err_q <= (in_data != csum);
`endif
      end
    end
  end

endmodule
